// File: rtl/insn_loader.sv
// Framed byte-stream loader: SYNC, LEN, big-endian 16-bit words, XOR checksum.
// Writes words into instruction memory from address 0 and holds the CPU while loading.
module insn_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DIN,
  output logic              MEM_WE,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM
  } state_t;

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         din_q, din_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [7:0]          acc_q, acc_d;

  logic                accept;
  logic [ADDR_W:0]     idx_inc;
  logic [ADDR_W:0]     n_full;

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    hold_d   = hold_q;
    err_d    = err_q;
    idx_d    = idx_q;
    n_d      = n_q;
    acc_d    = acc_q;
    accept   = RX_VALID && rdy_q;
    // Index and length are one bit wider than the address so a full-memory
    // frame reaches 2^ADDR_W without wrapping before the compare.
    idx_inc  = idx_q + (ADDR_W+1)'(1);
    n_full   = '0;
    n_full[ADDR_W] = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (accept && RX_DATA == SYNC) begin
          state_d = S_LEN;
          acc_d   = '0;
          idx_d   = '0;
          hold_d  = 1'b1;
        end
      end
      S_LEN: begin
        if (accept) begin
          n_d     = (RX_DATA == 8'h00) ? n_full : (ADDR_W+1)'(RX_DATA);
          acc_d   = acc_q ^ RX_DATA;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          din_d[15:8] = RX_DATA;
          acc_d       = acc_q ^ RX_DATA;
          state_d     = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          din_d[7:0] = RX_DATA;
          acc_d      = acc_q ^ RX_DATA;
          state_d    = S_WRITE;
          we_d       = 1'b1;
          addr_d     = idx_q[ADDR_W-1:0];
        end
      end
      S_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == n_q) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (accept) begin
          state_d = S_IDLE;
          if (RX_DATA == acc_q) begin
            done_d = 1'b1;
            err_d  = 1'b0;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d != S_WRITE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      n_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
    end
  end

  assign RX_READY = rdy_q;
  assign MEM_WE   = we_q;
  assign MEM_ADDR = addr_q;
  assign MEM_DIN  = din_q;
  assign CPU_HOLD = hold_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_insn_loader.sv
// Scoreboard bench for insn_loader: expected writes/DONE queued as bytes are driven,
// popped when the loader produces them.
module tb_insn_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_we;
  logic              cpu_hold;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  insn_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .CLK(clk), .RST_N(rst_n),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
    .MEM_ADDR(mem_addr), .MEM_DIN(mem_din), .MEM_WE(mem_we),
    .CPU_HOLD(cpu_hold), .DONE(done), .ERR(err)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         wr_q[$];
  int          done_q[$];
  logic [15:0] frame_words[$];
  int          lo_cnt = 0;
  int          lo_seen = 0;
  bit          gaps_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: WRITE must follow each accepted LO byte by exactly one cycle.
  always @(negedge clk) begin
    logic busy;
    wr_t  e;
    if (!rst_n) begin
      lo_seen = lo_cnt;
    end else begin
      busy    = (lo_cnt != lo_seen);
      lo_seen = lo_cnt;
      check("rx_ready", {31'b0, rx_ready}, {31'b0, !busy});
      check("mem_we", {31'b0, mem_we}, {31'b0, busy});
      if (mem_we) begin
        check("wr_expected", {31'b0, wr_q.size() > 0}, 32'd1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("wr_addr", {24'b0, mem_addr}, {24'b0, e.addr});
          check("wr_data", {16'b0, mem_din}, {16'b0, e.data});
        end
      end
      if (done) begin
        check("done_expected", {31'b0, done_q.size() > 0}, 32'd1);
        if (done_q.size() > 0) void'(done_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_lo);
    int n;
    bit ok;
    if (gaps_en && $urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(posedge clk);
      n++;
      ok = rx_ready;
    end
    if (!ok) check("rx_timeout", n, 0);
    if (is_lo && ok) lo_cnt++;
    #1;
  endtask

  task automatic send_frame(input bit bad);
    int          nw;
    logic [7:0]  len;
    logic [7:0]  cs;
    logic [15:0] w;
    nw  = frame_words.size();
    len = nw[7:0];
    cs  = len;
    send_byte(8'hA5, 1'b0);
    check("hold_on_sync", {31'b0, cpu_hold}, 32'd1);
    send_byte(len, 1'b0);
    for (int i = 0; i < nw; i++) begin
      w  = frame_words[i];
      cs = cs ^ w[15:8] ^ w[7:0];
      wr_q.push_back({i[7:0], w});
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b1);
    end
    check("hold_before_csum", {31'b0, cpu_hold}, 32'd1);
    if (!bad) done_q.push_back(1);
    send_byte(bad ? ~cs : cs, 1'b0);
    rx_valid = 1'b0;
    check("done_pulse", {31'b0, done}, {31'b0, !bad});
    check("err", {31'b0, err}, {31'b0, bad});
    check("hold_end", {31'b0, cpu_hold}, {31'b0, bad});
    repeat (3) @(negedge clk);
    #1;
    check("wr_pending", wr_q.size(), 0);
    check("done_pending", done_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", {31'b0, rx_ready}, 32'd1);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_din", {16'b0, mem_din}, 32'd0);
    check("rst_hold", {31'b0, cpu_hold}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
  endtask

  initial begin
    int nw;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Noise then a two-word frame
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    check("hold_noise", {31'b0, cpu_hold}, 32'd0);
    frame_words = '{16'h1234, 16'hABCD};
    send_frame(1'b0);

    // Bad checksum, then a good frame clears ERR
    send_frame(1'b1);
    send_frame(1'b0);

    // SYNC value as data
    frame_words = '{16'hA5A5};
    send_frame(1'b0);

    // Full memory: LEN = 0 means 256 words
    frame_words.delete();
    for (int k = 0; k < 256; k++) frame_words.push_back(16'(k));
    send_frame(1'b0);

    // Random stalls on RX_VALID
    gaps_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      frame_words.delete();
      nw = $urandom_range(1, 8);
      for (int k = 0; k < nw; k++) frame_words.push_back(16'($urandom));
      send_frame(1'b0);
    end
    gaps_en = 1'b0;

    // Reset after the HI byte of word 1
    wr_q.push_back({8'h00, 16'h1122});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    check("hold_mid_frame", {31'b0, cpu_hold}, 32'd1);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    check("wr_before_reset", wr_q.size(), 0);
    frame_words = '{16'h0BEE, 16'hCAFE};
    send_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/insn_loader.md
# insn_loader

Byte-stream program loader that writes the instruction memory's otherwise unused write port. A framed byte stream (sync, length, big-endian 16-bit words, XOR checksum) arrives over a valid/ready interface, typically from a UART receiver. The loader assembles the words and writes them into instruction memory starting at address 0. It holds the pipeline in reset while a load is in progress.

## Interface
- ADDR_W, 8: instruction memory address width; memory depth is 2^ADDR_W words.
- SYNC, 8'hA5: frame start byte.

- CLK  in  1  system clock (100 MHz).
- RST_N  in  1  synchronous, active-low reset.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA valid; a byte transfers when RX_VALID & RX_READY at the CLK edge.
- RX_READY  out  1  loader can accept a byte.
- MEM_ADDR  out  ADDR_W  instruction memory write address (wea/addra side).
- MEM_DIN  out  16  instruction word to write.
- MEM_WE  out  1  write strobe, one cycle per word.
- CPU_HOLD  out  1  hold pipeline in reset (OR into the pipeline's RST).
- DONE  out  1  one-cycle pulse when a frame completes with a good checksum.
- ERR  out  1  sticky; last frame failed its checksum.

## Operation
- Frame format: SYNC, LEN, then 2·N data bytes (high byte first per word), then CSUM.
  - N = LEN, except LEN = 0 means N = 2^ADDR_W (full memory).
  - CSUM = XOR of LEN and all data bytes.
- States: IDLE, LEN, HI, LO, WRITE, CSUM.
- IDLE
  - RX_READY = 1.
  - Non-SYNC bytes are discarded.
  - A SYNC byte moves to LEN, clears the checksum accumulator and word index, and sets CPU_HOLD = 1.
- LEN
  - The accepted byte sets the N counter (ADDR_W+1 bits) and is XORed into the checksum.
  - Next state: HI.
- HI
  - The accepted byte is latched as MEM_DIN[15:8] and XORed into the checksum.
  - Next state: LO.
- LO
  - The accepted byte is latched as MEM_DIN[7:0] and XORed into the checksum.
  - Next state: WRITE.
- WRITE (exactly one cycle)
  - MEM_WE = 1, MEM_ADDR = word index, RX_READY = 0.
  - The index increments.
  - If the incremented index equals N, go to CSUM; otherwise go to HI.
- CSUM
  - The accepted byte is compared with the accumulator.
  - Match: DONE pulses, ERR cleared, CPU_HOLD cleared.
  - Mismatch: ERR = 1 and CPU_HOLD stays 1; the memory contents are not trusted.
  - Either way, next state is IDLE.
- Mid-frame rules:
  - A SYNC value inside a frame is ordinary data. There is no resynchronisation.
  - RX_VALID low stalls the FSM in its current state with no timeout.
- A new SYNC in IDLE while ERR = 1 starts a fresh load. ERR stays set until that load succeeds.
- Addresses above N−1 are never written.

## Timing
- Reset values (RST_N low at an edge):
  - State = IDLE, RX_READY = 1, MEM_WE = 0.
  - MEM_ADDR = 0, MEM_DIN = 0.
  - CPU_HOLD = 0, DONE = 0, ERR = 0.
  - Index and accumulator = 0.
- Reset mid-frame aborts the frame immediately. Partial writes stay in memory, and CPU_HOLD drops.
- Byte acceptance is one byte per cycle in IDLE, LEN, HI, LO and CSUM.
- MEM_WE is asserted in the cycle after the LO byte is accepted. MEM_ADDR and MEM_DIN are stable for that whole cycle.
- Peak throughput is 2 bytes per 3 cycles, since RX_READY drops only during WRITE.
- CPU_HOLD:
  - rises on the edge that accepts SYNC;
  - falls on the edge that accepts a matching CSUM.
  - DONE is high in the cycle after that edge.
- The full N = 256 frame performs 256 writes to addresses 0..255. The index reaches 256 and must not wrap to 0 before the compare.
- All outputs are registered. No combinational path runs from RX_DATA or RX_VALID to any output.

## Test plan
- Noise then frame:
  - Stimulus: bytes 00, 13, A5, 02, 12, 34, AB, CD, then CSUM = 02^12^34^AB^CD.
  - Response: writes mem[0] = 1234 and mem[1] = ABCD; DONE pulses once; ERR = 0; CPU_HOLD high from the A5 edge until the CSUM edge.
- Bad checksum:
  - Stimulus: the same frame with CSUM inverted.
  - Response: ERR = 1, no DONE, CPU_HOLD stays 1.
  - Follow-up: a following good frame sets ERR = 0 and CPU_HOLD = 0.
- Embedded SYNC:
  - Stimulus: A5, 01, A5, A5, then CSUM = 01.
  - Response: mem[0] = A5A5 and DONE pulses; the embedded A5 bytes do not restart the frame.
- Full-memory frame:
  - Stimulus: LEN = 00 with 512 data bytes, word k = k.
  - Response: exactly 256 MEM_WE pulses at addresses 0..255, the last with MEM_DIN = 00FF; DONE pulses.
- Backpressure and stalls:
  - Stimulus: RX_VALID held high continuously, with random RX_VALID gaps inserted.
  - Response: RX_READY is low exactly in the cycle after each LO byte; no byte is lost or duplicated.
- Reset mid-frame:
  - Stimulus: RST_N low after the HI byte of word 1.
  - Response: all outputs return to their reset values on the next edge.
  - Follow-up: a following good frame loads correctly.
